// File: rtl/mem_access_ctrl.sv
// Single-access load/store sequencer between the memory stage and a variable-latency word memory.
// Optional misaligned-access exception is enabled by defining MISALIGN_EXC_EN.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] wd_q, wd_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  exc_q, exc_d;

  logic        misalign;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

`ifdef MISALIGN_EXC_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = req_wdata;
    case (req_size)
      2'b00: begin
        be_calc    = 4'b0001 << req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Extraction uses the offset/size latched at accept, not the live request.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (off_q)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          be_d    = req_we ? be_calc : 4'b1111;
          addr_d  = {req_addr[31:2], 2'b00};
          wdata_d = wdata_calc;
          wd_d    = 16'd0;
          rdata_d = 32'd0;
          if (misalign) begin
            exc_d   = 2'b01;
            state_d = RESP;
          end else begin
            exc_d   = 2'b00;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Ack beats the watchdog when both land in the same cycle.
        if (mem_ack) begin
          rdata_d = we_q ? 32'd0 : load_ext;
          exc_d   = 2'b00;
          state_d = RESP;
        end else if (wd_q == TIMEOUT_W) begin
          rdata_d = 32'd0;
          exc_d   = 2'b10;
          state_d = RESP;
        end else if (wd_q != 16'hFFFF) begin
          wd_d = wd_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      be_q    <= 4'b0000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wd_q    <= 16'd0;
      rdata_q <= 32'd0;
      exc_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_en     = (state_q == ACCESS);
  assign resp_valid = (state_q == RESP);
  assign mem_we     = we_q;
  assign mem_be     = be_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_exc   = exc_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl (TIMEOUT = 4); follows MISALIGN_EXC_EN if defined.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;

  int passed = 0;
  int total  = 0;

`ifdef MISALIGN_EXC_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rexp;
    logic [1:0]  exc;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    chk("req_ready_before", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.mis) begin
      chk("mis_mem_en", 32'(mem_en), 32'd0);
    end else begin
      for (int i = 0; i <= v.delay; i++) begin
        chk("mem_en", 32'(mem_en), 32'd1);
        chk("resp_valid_busy", 32'(resp_valid), 32'd0);
        if (i == 0) begin
          chk("mem_we", 32'(mem_we), 32'(v.we));
          chk("mem_be", 32'(mem_be), 32'(v.be));
          chk("mem_addr", mem_addr, v.maddr);
          if (v.we) chk("mem_wdata", mem_wdata, v.mwdata);
        end
        if (i == v.delay) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_0000;
      end
      chk("mem_en_done", 32'(mem_en), 32'd0);
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_rdata", resp_rdata, v.rexp);
    chk("resp_exc", 32'(resp_exc), 32'(v.exc));
    $display("vec %0d: we=%0d size=%0d addr=0x%08h -> rdata=0x%08h exc=%0d", idx, v.we, v.size,
             v.addr, resp_rdata, resp_exc);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    // we size uns addr wdata rdata delay mis be maddr mwdata rexp exc
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0,
                 4'b1111, 32'h100, 32'h0, 32'hFFFF_FF80, 2'b00};
    vecs[1]  = '{1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h9ABC_5678, 3, 1'b0,
                 4'b1111, 32'h200, 32'h0, 32'h0000_9ABC, 2'b00};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h301, 32'h55, 32'h0, 0, 1'b0,
                 4'b0010, 32'h300, 32'h5555_5555, 32'h0, 2'b00};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h302, 32'hBEEF, 32'h0, 1, 1'b0,
                 4'b1100, 32'h300, 32'hBEEF_BEEF, 32'h0, 2'b00};
    if (MIS_EN)
      vecs[4] = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h1234_5678, 0, 1'b1,
                  4'b1111, 32'h100, 32'h0, 32'h0, 2'b01};
    else
      vecs[4] = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h1234_5678, 0, 1'b0,
                  4'b1111, 32'h100, 32'h0, 32'h1234_5678, 2'b00};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'hA1B2_C3D4, 1, 1'b0,
                 4'b1111, 32'h100, 32'h0, 32'h0000_00C3, 2'b00};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h400, 32'h0, 32'h1234_8001, 0, 1'b0,
                 4'b1111, 32'h400, 32'h0, 32'hFFFF_8001, 2'b00};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h500, 32'hDEAD_BEEF, 32'h0, 0, 1'b0,
                 4'b1111, 32'h500, 32'hDEAD_BEEF, 32'h0, 2'b00};
    // Ack lands on the same cycle the watchdog expires: must succeed.
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 32'hCAFE_F00D, 4, 1'b0,
                 4'b1111, 32'h600, 32'h0, 32'hCAFE_F00D, 2'b00};
    if (MIS_EN)
      vecs[9] = '{1'b1, 2'b01, 1'b0, 32'h303, 32'h1234, 32'h0, 0, 1'b1,
                  4'b1100, 32'h300, 32'h1234_1234, 32'h0, 2'b01};
    else
      vecs[9] = '{1'b1, 2'b01, 1'b0, 32'h303, 32'h1234, 32'h0, 0, 1'b0,
                  4'b1100, 32'h300, 32'h1234_1234, 32'h0, 2'b00};
    vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h703, 32'hFFFF_FFA5, 32'h0, 2, 1'b0,
                 4'b1000, 32'h700, 32'hA5A5_A5A5, 32'h0, 2'b00};

    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_exc", 32'(resp_exc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ack while idle must be ignored.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_resp_valid", 32'(resp_valid), 32'd0);
    chk("idle_ack_req_ready", 32'(req_ready), 32'd1);
    $display("idle ack: resp_valid=%0d req_ready=%0d", resp_valid, req_ready);

    for (int k = 0; k < 11; k++) run_vec(k);

    // Timeout: no ack, response five cycles after mem_en rises.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h800; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("to_mem_en", 32'(mem_en), 32'd1);
      chk("to_resp_valid_busy", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("to_resp_valid", 32'(resp_valid), 32'd1);
    chk("to_resp_exc", 32'(resp_exc), 32'd2);
    chk("to_resp_rdata", resp_rdata, 32'd0);
    chk("to_mem_en_off", 32'(mem_en), 32'd0);
    $display("timeout: resp_valid=%0d exc=%0d rdata=0x%08h", resp_valid, resp_exc, resp_rdata);
    @(negedge clk);
    chk("to_resp_pulse", 32'(resp_valid), 32'd0);
    chk("to_req_ready", 32'(req_ready), 32'd1);

    // Asynchronous reset mid-access, then a late ack.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h900; req_wdata = 32'h1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ar_mem_en_before", 32'(mem_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mem_en", 32'(mem_en), 32'd0);
    chk("ar_resp_valid", 32'(resp_valid), 32'd0);
    chk("ar_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ar_no_resp1", 32'(resp_valid), 32'd0);
    chk("ar_idle_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("ar_no_resp2", 32'(resp_valid), 32'd0);
    chk("ar_req_ready2", 32'(req_ready), 32'd1);
    $display("async reset: mem_en=%0d resp_valid=%0d req_ready=%0d", mem_en, resp_valid, req_ready);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
